// File: rtl/mc_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute states and drives
// every datapath enable, the ALU operation class and the jmor PC-from-MDR path.
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       jmorsig,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       aluop2,
  output logic       aluop1,
  output logic       aluop0,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BEQ    = 4'd8,
    JUMP   = 4'd9,
    ANDIEX = 4'd10,
    ANDIWB = 4'd11,
    JMORRD = 4'd12,
    JMORPC = 4'd13
  } state_t;

  // Per-state control word; 'fetch' marks the state whose irwrite/pcwrite follow mem_ready.
  typedef struct packed {
    logic [2:0] aluop;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       fetch;
  } ctrl_t;

  state_t state_q;
  state_t state_nxt;
  ctrl_t  ctrl_q;
  logic   unused_zero;

  function automatic logic is_legal(input logic [5:0] op);
    is_legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ANDI) || (op == OP_J);
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic js, input logic rdy);
    next_state = FETCH;
    case (s)
      FETCH:  next_state = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = RTEXEC;
          OP_BEQ:       next_state = BEQ;
          OP_J:         next_state = JUMP;
          OP_ANDI:      next_state = ANDIEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: next_state = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  next_state = rdy ? MEMWB : MEMRD;
      MEMWB:  next_state = FETCH;
      MEMWR:  next_state = rdy ? FETCH : MEMWR;
      RTEXEC: next_state = js ? JMORRD : RTWB;
      RTWB:   next_state = FETCH;
      BEQ:    next_state = FETCH;
      JUMP:   next_state = FETCH;
      ANDIEX: next_state = ANDIWB;
      ANDIWB: next_state = FETCH;
      JMORRD: next_state = rdy ? JMORPC : JMORRD;
      JMORPC: next_state = FETCH;
      default: next_state = FETCH;
    endcase
  endfunction

  function automatic ctrl_t decode(input state_t s);
    decode = '0;
    case (s)
      FETCH: begin
        decode.memread = 1'b1;
        decode.alusrcb = 2'b01;
        decode.fetch   = 1'b1;
      end
      DECODE: decode.alusrcb = 2'b11;
      MEMADR: begin
        decode.alusrca = 1'b1;
        decode.alusrcb = 2'b10;
      end
      MEMRD, JMORRD: begin
        decode.memread = 1'b1;
        decode.iord    = 1'b1;
      end
      MEMWB: begin
        decode.regwrite = 1'b1;
        decode.memtoreg = 1'b1;
      end
      MEMWR: begin
        decode.memwrite = 1'b1;
        decode.iord     = 1'b1;
      end
      RTEXEC: begin
        decode.alusrca = 1'b1;
        decode.aluop   = 3'b010;
      end
      RTWB: begin
        decode.regwrite = 1'b1;
        decode.regdst   = 1'b1;
        decode.aluop    = 3'b010;
      end
      BEQ: begin
        decode.alusrca     = 1'b1;
        decode.aluop       = 3'b001;
        decode.pcwritecond = 1'b1;
        decode.pcsource    = 2'b01;
      end
      JUMP: begin
        decode.pcwrite  = 1'b1;
        decode.pcsource = 2'b10;
      end
      ANDIEX: begin
        decode.alusrca = 1'b1;
        decode.alusrcb = 2'b10;
        decode.aluop   = 3'b100;
      end
      ANDIWB: begin
        decode.regwrite = 1'b1;
        decode.aluop    = 3'b100;
      end
      JMORPC: begin
        decode.pcwrite  = 1'b1;
        decode.pcsource = 2'b11;
      end
      default: decode = '0;
    endcase
  endfunction

  assign state_nxt = next_state(state_q, opcode, jmorsig, mem_ready);

  // The control word is registered alongside the state so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= decode(FETCH);
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode(state_nxt);
    end
  end

  // The branch decision is taken in the datapath, which ANDs pcwritecond with zero.
  assign unused_zero = zero;

  assign aluop2      = ctrl_q.aluop[2];
  assign aluop1      = ctrl_q.aluop[1];
  assign aluop0      = ctrl_q.aluop[0];
  assign pcwrite     = ctrl_q.pcwrite | (ctrl_q.fetch & mem_ready);
  assign irwrite     = ctrl_q.fetch & mem_ready;
  assign pcwritecond = ctrl_q.pcwritecond;
  assign iord        = ctrl_q.iord;
  assign memread     = ctrl_q.memread;
  assign memwrite    = ctrl_q.memwrite;
  assign memtoreg    = ctrl_q.memtoreg;
  assign regwrite    = ctrl_q.regwrite;
  assign regdst      = ctrl_q.regdst;
  assign alusrca     = ctrl_q.alusrca;
  assign alusrcb     = ctrl_q.alusrcb;
  assign pcsource    = ctrl_q.pcsource;
  assign illegal     = (state_q == DECODE) && !is_legal(opcode);
  assign state       = state_q;

endmodule
